// File: rtl/ring_output_vc_arbiter.sv
// ---------------------------------------------------------------------------
// ring_output_vc_arbiter
//
// Controller for one output channel of the bidirectional-ring router. Two
// input buffers compete for this output. The block keeps one output register
// per virtual channel (even/odd). Each cycle the router polarity bit picks
// the "internal" VC. Requests for that VC are arbitrated round-robin and
// captured into its register. In the same cycle, the register of the other
// ("external") VC is offered to the downstream link under a send/ready
// handshake.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   polarity  : router phase bit (internal VC = polarity, external = ~polarity)
//   req0/1    : requester k has a packet for this output
//   data0/1   : requester k packet (bit 63 VC, bit 62 direction, 55:48 hop)
//   gnt0/1    : requester k packet is captured at this rising edge
//   so        : send strobe to downstream
//   ro        : downstream ready
//   dout      : packet to downstream (zero when nothing is held)
//   vc_full   : per-VC register valid bits (bit 0 even, bit 1 odd)
// ---------------------------------------------------------------------------
module ring_output_vc_arbiter #(
    parameter int PACKET_SIZE = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    input  logic                   req0,
    input  logic [PACKET_SIZE-1:0] data0,
    output logic                   gnt0,
    input  logic                   req1,
    input  logic [PACKET_SIZE-1:0] data1,
    output logic                   gnt1,
    output logic                   so,
    input  logic                   ro,
    output logic [PACKET_SIZE-1:0] dout,
    output logic [1:0]             vc_full
);

    localparam int VC_BIT = PACKET_SIZE - 1;
    localparam int HOP_HI = 55;
    localparam int HOP_LO = 48;

    logic [1:0]             r_valid;
    logic [1:0]             r_rr_last;   // per VC: index of last granted requester
    logic [PACKET_SIZE-1:0] r_buf0;
    logic [PACKET_SIZE-1:0] r_buf1;

    logic                   w_iv;
    logic                   w_ev;
    logic                   w_elig0;
    logic                   w_elig1;
    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_any_gnt;
    logic [PACKET_SIZE-1:0] w_sel;
    logic [PACKET_SIZE-1:0] w_cap;
    logic                   w_send;

    assign w_iv = polarity;
    assign w_ev = ~polarity;

    // A request tagged for the external VC simply waits for its phase.
    // A full internal register blocks all grants (no same-cycle bypass).
    assign w_elig0 = req0 && (data0[VC_BIT] == w_iv) && !r_valid[w_iv];
    assign w_elig1 = req1 && (data1[VC_BIT] == w_iv) && !r_valid[w_iv];

    // On contention the requester that was not granted last on this VC wins.
    // Gated by reset so no grant is visible while the block is held in reset.
    assign w_gnt0 = reset && w_elig0 && (!w_elig1 || r_rr_last[w_iv]);
    assign w_gnt1 = reset && w_elig1 && (!w_elig0 || !r_rr_last[w_iv]);
    assign w_any_gnt = w_gnt0 || w_gnt1;

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    assign w_sel = w_gnt1 ? data1 : data0;

    // Hop field is halved on the way through; everything else passes as is.
    always_comb begin
        w_cap                 = w_sel;
        w_cap[HOP_HI:HOP_LO]  = {1'b0, w_sel[HOP_HI:HOP_LO+1]};
    end

    assign w_send = r_valid[w_ev] && ro;
    assign so     = w_send;

    always_comb begin
        dout = '0;
        if (r_valid[w_ev]) begin
            dout = w_ev ? r_buf1 : r_buf0;
        end
    end

    assign vc_full = r_valid;

    // Grant on iv and send on ev always touch different VCs, so both
    // updates can land in the same edge without interfering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 2'b00;
            r_rr_last <= 2'b11;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            if (w_any_gnt) begin
                r_valid[w_iv]   <= 1'b1;
                r_rr_last[w_iv] <= w_gnt1;
                if (w_iv) begin
                    r_buf1 <= w_cap;
                end else begin
                    r_buf0 <= w_cap;
                end
            end
            if (w_send) begin
                r_valid[w_ev] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_output_vc_arbiter.sv
module tb_ring_output_vc_arbiter;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        req0;
    logic [63:0] data0;
    logic        gnt0;
    logic        req1;
    logic [63:0] data1;
    logic        gnt1;
    logic        so;
    logic        ro;
    logic [63:0] dout;
    logic [1:0]  vc_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];

    ring_output_vc_arbiter #(.PACKET_SIZE(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .req0     (req0),
        .data0    (data0),
        .gnt0     (gnt0),
        .req1     (req1),
        .data1    (data1),
        .gnt1     (gnt1),
        .so       (so),
        .ro       (ro),
        .dout     (dout),
        .vc_full  (vc_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {vc, dir, 6'h2A, hop, tag}
    function automatic logic [63:0] pkt(input logic vc, input logic dir,
                                        input logic [7:0] hop, input logic [47:0] tag);
        return {vc, dir, 6'h2A, hop, tag};
    endfunction

    // Scoreboard monitor: every send must match the oldest expected packet.
    always @(negedge clk) begin
        if (so === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_send", dout, 64'h0);
                n_fail += (dout === 64'h0) ? 1 : 0;
                if (dout === 64'h0)
                    $display("FAIL unexpected_send: so=1 with empty scoreboard at %0t", $time);
            end else begin
                chk("send_dout", dout, exp_q.pop_front());
            end
        end
    end

    // Drive point is 1 time unit after the rising edge; polarity toggles there.
    task automatic tick();
        @(posedge clk);
        #1;
        polarity = ~polarity;
    endtask

    task automatic go_phase(input logic p);
        if (polarity !== p) tick();
    endtask

    task automatic idle_reqs();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        polarity = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        data0    = '0;
        data1    = '0;
        ro       = 1'b0;

        // Reset held 5 cycles with a live request: nothing may come out.
        req0  = 1'b1;
        data0 = pkt(1'b0, 1'b0, 8'h0F, 48'h111111111111);
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("rst_so",      so,      1'b0);
            chk("rst_gnt0",    gnt0,    1'b0);
            chk("rst_gnt1",    gnt1,    1'b0);
            chk("rst_vc_full", vc_full, 2'b00);
            tick();
        end
        idle_reqs();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("idle_so",      so,      1'b0);
            chk("idle_gnt",     {gnt1, gnt0}, 2'b00);
            chk("idle_vc_full", vc_full, 2'b00);
            chk("idle_dout",    dout,    64'h0);
            tick();
        end

        // No contention, VC0, hop 0F -> 07.
        go_phase(1'b0);
        ro    = 1'b1;
        req0  = 1'b1;
        data0 = pkt(1'b0, 1'b1, 8'h0F, 48'hABCDEF012345);
        #2;
        chk("nc_gnt0", gnt0, 1'b1);
        chk("nc_gnt1", gnt1, 1'b0);
        exp_q.push_back(pkt(1'b0, 1'b1, 8'h07, 48'hABCDEF012345));
        tick();
        idle_reqs();
        #2;
        chk("nc_so",      so,      1'b1);
        chk("nc_vc_full", vc_full, 2'b01);
        tick();
        #2;
        chk("nc_vc_empty", vc_full, 2'b00);

        // Wrong-phase request on requester 1 (VC1 while polarity=0).
        go_phase(1'b0);
        req1  = 1'b1;
        data1 = pkt(1'b1, 1'b0, 8'h20, 48'h000000C0FFEE);
        #2;
        chk("wp_gnt1_even", gnt1, 1'b0);
        tick();
        #2;
        chk("wp_gnt1_odd", gnt1, 1'b1);
        exp_q.push_back(pkt(1'b1, 1'b0, 8'h10, 48'h000000C0FFEE));
        tick();
        idle_reqs();
        #2;
        chk("wp_so", so, 1'b1);
        tick();

        // Fresh reset so round-robin starts from requester 0 on VC0.
        #2;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();

        // Contention on VC0 over four even phases: 0,1,0,1, hop 04 -> 02.
        for (int i = 0; i < 4; i++) begin
            go_phase(1'b0);
            req0  = 1'b1;
            req1  = 1'b1;
            data0 = pkt(1'b0, 1'b0, 8'h04, 48'hA00000000000 + 48'(i));
            data1 = pkt(1'b0, 1'b1, 8'h04, 48'hB00000000000 + 48'(i));
            #2;
            chk("rr_gnt0", gnt0, (i % 2 == 0));
            chk("rr_gnt1", gnt1, (i % 2 == 1));
            if (i % 2 == 0)
                exp_q.push_back(pkt(1'b0, 1'b0, 8'h02, 48'hA00000000000 + 48'(i)));
            else
                exp_q.push_back(pkt(1'b0, 1'b1, 8'h02, 48'hB00000000000 + 48'(i)));
            tick();
            idle_reqs();
            #2;
            chk("rr_so", so, 1'b1);
            tick();
        end

        // Backpressure on VC0.
        go_phase(1'b0);
        ro    = 1'b0;
        req0  = 1'b1;
        data0 = pkt(1'b0, 1'b0, 8'h40, 48'h0000DEADBEEF);
        #2;
        chk("bp_gnt0", gnt0, 1'b1);
        exp_q.push_back(pkt(1'b0, 1'b0, 8'h20, 48'h0000DEADBEEF));
        tick();
        idle_reqs();
        #2;
        chk("bp_so_held",   so,      1'b0);
        chk("bp_vc_full",   vc_full, 2'b01);
        tick();
        req0  = 1'b1;
        data0 = pkt(1'b0, 1'b0, 8'h80, 48'h000012345678);
        #2;
        chk("bp_gnt0_blocked", gnt0, 1'b0);
        chk("bp_vc_full2",     vc_full, 2'b01);
        tick();
        idle_reqs();
        ro = 1'b1;
        #2;
        chk("bp_so_release", so, 1'b1);
        tick();
        req0  = 1'b1;
        data0 = pkt(1'b0, 1'b0, 8'h02, 48'h000055AA55AA);
        #2;
        chk("bp_vc_empty", vc_full, 2'b00);
        chk("bp_gnt0_again", gnt0, 1'b1);
        exp_q.push_back(pkt(1'b0, 1'b0, 8'h01, 48'h000055AA55AA));
        tick();
        idle_reqs();
        #2;
        chk("bp_so_again", so, 1'b1);
        tick();

        // Both VCs full under ro=0, then a mid-cycle reset pulse.
        go_phase(1'b0);
        ro    = 1'b0;
        req0  = 1'b1;
        data0 = pkt(1'b0, 1'b0, 8'h10, 48'h0000000F00D0);
        #2;
        chk("mr_gnt0", gnt0, 1'b1);
        tick();
        req0  = 1'b0;
        req1  = 1'b1;
        data1 = pkt(1'b1, 1'b0, 8'h10, 48'h0000000F00D1);
        #2;
        chk("mr_gnt1", gnt1, 1'b1);
        tick();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = pkt(1'b0, 1'b0, 8'h10, 48'h000000000001);
        data1 = pkt(1'b1, 1'b0, 8'h10, 48'h000000000002);
        #2;
        chk("mr_both_full",   vc_full, 2'b11);
        chk("mr_gnts_zero",   {gnt1, gnt0}, 2'b00);
        idle_reqs();
        ro    = 1'b1;
        reset = 1'b0;
        #1;
        chk("mr_rst_vc_full", vc_full, 2'b00);
        chk("mr_rst_so",      so,      1'b0);
        #4;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #2;
            chk("mr_no_send", so, 1'b0);
        end

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_output_vc_arbiter.md
Name: ring_output_vc_arbiter

Overview:
- Controller for one output channel of the bidirectional-ring gold router (cw, ccw or pe output).
- Two input buffers compete for the channel: for the cw output, these are the cw input buffer and the pe input buffer.
- The block holds one output register per virtual channel (even/odd) and arbitrates round-robin between the requesters for the internally-active VC.
- In the same cycle, it drives the opposite VC's register onto the external link under a send/ready handshake, phased by the router's polarity bit.

Parameters:
- PACKET_SIZE, 64: packet width in bits.
  - Bit 63 = VC (0 even, 1 odd).
  - Bit 62 = direction.
  - Bits 55:48 = hop field.

Ports:
- clk, input, 1: system clock, rising-edge.
- reset, input, 1: asynchronous, active-low reset (reset==0 clears state immediately).
- polarity, input, 1: router phase bit, toggles every cycle; supplied by the router.
- req0, input, 1: requester 0 has a packet destined to this output.
- data0, input, PACKET_SIZE: requester 0 packet.
- gnt0, output, 1: requester 0 packet accepted at this rising edge.
- req1, input, 1: requester 1 request.
- data1, input, PACKET_SIZE: requester 1 packet.
- gnt1, output, 1: requester 1 accept.
- so, output, 1: send to downstream.
- ro, input, 1: downstream ready.
- dout, output, PACKET_SIZE: packet to downstream.
- vc_full, output, 2: per-VC occupancy. Bit 0 = even register valid, bit 1 = odd register valid.

Behaviour:
- State:
  - valid[1:0] and buf0/buf1 (PACKET_SIZE each).
  - rr_last[1:0]: per-VC last-granted pointer.
- Reset (reset==0, asynchronous):
  - valid=0, buf0=buf1=0, rr_last=2'b11 (so requester 0 wins first on each VC).
  - Outputs so=0, gnt0=gnt1=0, dout=0, vc_full=0.
  - A reset asserted mid-operation drops held packets. There is no partial transfer.
- Phase:
  - Internal VC iv = polarity.
  - External VC ev = ~polarity.
- Eligibility:
  - Requester k is eligible iff reqk && datak[63]==iv && valid[iv]==0.
  - Requests tagged with VC ev are never granted this cycle; the requester retries next cycle.
- Arbitration (combinational gnt):
  - One eligible requester: it is granted.
  - Both eligible: grant the one with index != rr_last[iv].
  - gnt0 and gnt1 are never both 1.
  - gnt is 0 whenever valid[iv]==1; there is no same-cycle bypass/drain of the internal VC.
- Capture (rising edge with gntk=1):
  - buf[iv] <= datak with bits 55:48 replaced by datak[55:48]>>1 (logical shift right, MSB filled 0). All other bits unchanged.
  - valid[iv] <= 1.
  - rr_last[iv] <= k.
  - rr_last of the other VC is unchanged.
- External send (combinational):
  - so = valid[ev] && ro.
  - dout = buf[ev] when valid[ev], else 0.
  - At a rising edge with so==1: valid[ev] <= 0. buf is retained but not visible.
  - ro low: the register holds indefinitely and its VC stops accepting grants.
- Latency:
  - A packet granted at edge N (polarity p) is sent at the earliest in the cycle after edge N, when polarity has flipped to ~p, if ro=1. That is one cycle.
  - If ro=0 in that cycle, the next send opportunity is two cycles later (same phase).
- Simultaneous events:
  - Grant on iv and send on ev in the same cycle are independent and both take effect.
  - Both VCs full with ro=0: both gnts stay 0.
- vc_full = valid (registered state), for router status/debug.
- Polarity is not checked for toggling. If it stalls, the block simply keeps serving the same phase.

Test Plan:
- Reset low 5 cycles, then high.
  - During reset, so, gnt0, gnt1 and vc_full are all 0.
  - After reset release, with no req, outputs stay 0.
- No contention:
  - Stimulus: polarity=0, req0=1, data0 = VC0, hop 8'h0F, ro=1.
  - Response: gnt0=1 that cycle.
  - Next cycle (polarity=1): so=1 and dout[55:48]=8'h07, other bits equal to data0.
  - vc_full returns to 0 after that edge.
- Wrong-phase request:
  - Stimulus: req1=1 with data1[63]=1 while polarity=0.
  - Response: gnt1=0. On the next cycle (polarity=1), gnt1=1.
- Contention and round-robin on VC0:
  - Stimulus: req0 and req1 both VC0, hop 8'h04, ro=1, repeated over four even phases.
  - Response: grants alternate 0,1,0,1, and each dout hop is 8'h02.
- Backpressure:
  - Stimulus: ro=0 after a capture on VC0.
  - Response: so=0, vc_full[0]=1, and further VC0 requests see gnt=0.
  - Raising ro in an odd-polarity cycle gives so=1 and releases the register. The next even phase grants again.
- Reset mid-operation:
  - Stimulus: both VC registers full, ro=0, then reset pulsed low for one half-cycle between edges.
  - Response: vc_full=0 and so=0 immediately. The held packets are never sent.
